instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Registered decode stage for the 9-bit ISA. It sits between instruction fetch and execute, and accepts one 9-bit instruction plus its PC per handshake. It emits the decoded control bundle, keyed to the shared opcode package, through a 2-entry skid buffer. It also supports a flush on taken branches and keeps a retired-decode counter.

## Interface
- PC_W, default 10: program counter width.
- CNT_W, default 16: decode counter width.
- Clk, in, 1: sole clock; all state updates on rising edge.
- Reset, in, 1: synchronous, active-high.
- in_valid, in, 1: fetch presents an instruction.
- in_instr, in, 9: instruction; [8:5] opcode, [4:0] operand.
- in_pc, in, PC_W: PC of in_instr.
- in_ready, out, 1: stage can accept; registered, equals !skid_full.
- flush, in, 1: discard all held and incoming instructions this cycle.
- out_valid, out, 1: decoded bundle valid.
- out_ready, in, 1: execute accepts bundle.
- out_op, out, 4: opcode, typed as the package op enum.
- out_imm, out, 5: operand[4:0] zero-extended to 5 bits, raw.
- out_rs, out, 3: operand[2:0].
- out_pc, out, PC_W: PC carried through.
- out_wr_reg, out, 1: writes general register.
- out_wr_rc, out, 1: writes RC register.
- out_mem_rd, out, 1: load.
- out_mem_wr, out, 1: store.
- out_branch, out, 1: branch.
- out_illegal, out, 1: reserved encoding.
- decode_cnt, out, CNT_W: count of bundles accepted by execute.

## Operation
- Decode per opcode:
  - RC_ADD, RC_SUB, RC_LOAD, LFSR: wr_rc=1.
  - RC_TRANSFER, PARITY_BIT, REG_COPY, ADD, SUB, XOR, AND, LSL, LSR: wr_reg=1.
  - CMP: no write flags; it only sets flags in execute.
  - MEM_OP: operand[4]=1 is a store (mem_wr=1); operand[4]=0 is a load (mem_rd=1, wr_reg=1).
  - BRANCH: branch=1, and out_imm is the LUT index.
  - All flags not listed for an opcode are 0.
- Illegal encoding: MEM_OP with operand[3]=1 sets illegal=1 and forces all write, mem and branch flags to 0. The bundle is still delivered.
- Storage: a main output register (out_*) plus one skid entry.
  - Input accepted when in_valid && in_ready && !flush.
  - If the main register is empty, or is being drained this cycle (out_valid && out_ready), the accepted instruction goes to main. Otherwise it goes to skid.
  - When main drains and skid is full, skid moves to main. If a new accept happens in the same cycle, the new instruction goes to skid.
- States: EMPTY (main empty, skid empty) → ONE (main full) → TWO (main and skid full). Transitions follow accept/drain counts; the sequence EMPTY→TWO in one cycle is impossible.
- in_ready = (state != TWO), registered.
- Flush: the next state is EMPTY, the input is not accepted, decode_cnt is unchanged, and flush takes precedence over every other event. A drain in the same flush cycle still completes: decode_cnt increments when out_valid && out_ready is sampled, even with flush.
- decode_cnt increments by 1 per out_valid && out_ready cycle and wraps at 2^CNT_W.
- Reset: state EMPTY, out_valid=0, in_ready=1, decode_cnt=0, all out_* bundle fields 0 (out_op = RC_ADD encoding 4'b0000).

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on out_* after edge N, provided main was empty.
- Throughput is 1 per cycle while out_ready=1.
- out_* stays stable while out_valid && !out_ready; there is no combinational path from out_ready to in_ready.
- Reset asserted mid-stream drops held instructions with no partial output.

## Structure
- Add to the shared definitions package:
  - the field-slice constants (opcode [8:5], rs [2:0], MEM_OP store bit 4, reserved bit 3);
  - a packed struct for the decoded bundle (op enum, imm, rs, pc, flags).
- One sub-module is natural: instr_decode_comb. It is purely combinational, maps 9 bits to the flag bundle, and is instantiated once before the skid logic.

## Test plan
- Reset, then in_instr=9'b0111_00011 (ADD, rs=3) with out_ready=1 → next cycle out_valid=1, out_op=ADD, out_rs=3, wr_reg=1, decode_cnt increments to 1 one cycle later.
- Hold out_ready=0 and send three instructions back-to-back → after two accepts in_ready=0; main holds the first, skid holds the second, and the third is held by fetch. Raise out_ready → delivery in order 1, 2, 3 with no bubble.
- MEM_OP 9'b1101_10010 → mem_wr=1, rs=2. MEM_OP 9'b1101_01000 → illegal=1 with all other flags 0.
- BRANCH 9'b1111_10101 → branch=1, out_imm=21, wr_reg=wr_rc=0.
- State TWO with out_ready=1 and flush=1 → one bundle consumed (decode_cnt +1), next cycle out_valid=0 and in_ready=1.
- Preload decode_cnt to 16'hFFFF via 65535 transfers, then one more transfer → decode_cnt=0. Assert Reset mid-stream → out_valid=0 on the next edge.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// instr_decode_stage_pkg: shared 9-bit ISA opcodes, field slices and decoded bundle types
package instr_decode_stage_pkg;
  typedef enum logic [3:0] {
    RC_ADD = 4'd0, RC_SUB = 4'd1, RC_LOAD = 4'd2, LFSR = 4'd3,
    RC_TRANSFER = 4'd4, PARITY_BIT = 4'd5, REG_COPY = 4'd6, ADD = 4'd7,
    SUB = 4'd8, XOR = 4'd9, AND = 4'd10, LSL = 4'd11,
    LSR = 4'd12, MEM_OP = 4'd13, CMP = 4'd14, BRANCH = 4'd15
  } opcode_e;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} stageState_e;
  localparam int OPC_HI = 8;
  localparam int OPC_LO = 5;
  localparam int RS_HI = 2;
  localparam int RS_LO = 0;
  localparam int MEM_STORE_BIT = 4;
  localparam int MEM_RSVD_BIT = 3;
  // Widest PC the bundle can carry; stages narrow it to their own PC_W.
  localparam int PC_MAX = 16;
  typedef struct packed {
    opcode_e op;
    logic [4:0] imm;
    logic [2:0] rs;
    logic wrReg;
    logic wrRc;
    logic memRd;
    logic memWr;
    logic branch;
    logic illegal;
  } decCtrl_t;
  typedef struct packed {
    decCtrl_t ctrl;
    logic [PC_MAX-1:0] pc;
  } decBundle_t;
endpackage

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: fetch-side and execute-side handshakes of the decode stage
interface instr_decode_stage_if import instr_decode_stage_pkg::*; #(parameter int PC_W = 10, parameter int CNT_W = 16);
  logic in_valid;
  logic [8:0] in_instr;
  logic [PC_W-1:0] in_pc;
  logic in_ready;
  logic flush;
  logic out_valid;
  logic out_ready;
  opcode_e out_op;
  logic [4:0] out_imm;
  logic [2:0] out_rs;
  logic [PC_W-1:0] out_pc;
  logic out_wr_reg;
  logic out_wr_rc;
  logic out_mem_rd;
  logic out_mem_wr;
  logic out_branch;
  logic out_illegal;
  logic [CNT_W-1:0] decode_cnt;
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input in_ready, out_valid, out_op, out_imm, out_rs, out_pc, out_wr_reg, out_wr_rc,
          out_mem_rd, out_mem_wr, out_branch, out_illegal, decode_cnt
  );
  modport slave (
    input in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_op, out_imm, out_rs, out_pc, out_wr_reg, out_wr_rc,
           out_mem_rd, out_mem_wr, out_branch, out_illegal, decode_cnt
  );
endinterface

// File: rtl/instr_decode_stage_comb.sv
// instr_decode_comb: purely combinational map from a 9-bit instruction to its control fields
module instr_decode_comb import instr_decode_stage_pkg::*; (
  input logic [8:0] instr,
  output decCtrl_t ctrl
);
  opcode_e op;
  logic isMem, rsvd, store;
  assign op = opcode_e'(instr[OPC_HI:OPC_LO]);
  assign isMem = op == MEM_OP;
  assign store = instr[MEM_STORE_BIT];
  assign rsvd = isMem && instr[MEM_RSVD_BIT];
  // A reserved MEM_OP is still delivered, but with every side effect suppressed.
  always_comb begin
    ctrl = '0;
    ctrl.op = op;
    ctrl.imm = instr[4:0];
    ctrl.rs = instr[RS_HI:RS_LO];
    ctrl.illegal = rsvd;
    ctrl.wrRc = op inside {RC_ADD, RC_SUB, RC_LOAD, LFSR};
    ctrl.wrReg = !rsvd && ((op inside {RC_TRANSFER, PARITY_BIT, REG_COPY, ADD, SUB, XOR, AND, LSL, LSR})
                 || (isMem && !store));
    ctrl.memRd = !rsvd && isMem && !store;
    ctrl.memWr = !rsvd && isMem && store;
    ctrl.branch = op == BRANCH;
  end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered decode with a 2-entry skid buffer, flush and retired-decode counter
module instr_decode_stage import instr_decode_stage_pkg::*; #(
  parameter int PC_W = 10,
  parameter int CNT_W = 16
) (
  input logic Clk,
  input logic Reset,
  instr_decode_stage_if.slave bus
);
  decCtrl_t ctrl;
  decBundle_t incoming, mainQ, skidQ;
  stageState_e state, nextState;
  logic inReadyQ, accept, drain;
  logic [CNT_W-1:0] cntQ;
  instr_decode_comb u_dec (.instr(bus.in_instr), .ctrl(ctrl));
  assign incoming = {ctrl, PC_MAX'(bus.in_pc)};
  assign accept = bus.in_valid && inReadyQ && !bus.flush;
  assign drain = bus.out_valid && bus.out_ready;
  always_ff @(posedge Clk) state <= Reset ? EMPTY : nextState;
  // TWO never sees an accept because in_ready is low there.
  always_comb
    nextState = bus.flush ? EMPTY :
                state == EMPTY ? (accept ? ONE : EMPTY) :
                state == ONE ? (accept == drain ? ONE : accept ? TWO : EMPTY) :
                (drain && !accept ? ONE : TWO);
  always_ff @(posedge Clk)
    if (Reset) begin
      mainQ <= '0;
      skidQ <= '0;
      inReadyQ <= 1'b1;
      cntQ <= '0;
    end else begin
      inReadyQ <= nextState != TWO;
      cntQ <= cntQ + CNT_W'(drain);
      if (drain && state == TWO) mainQ <= skidQ;
      else if (accept && (state == EMPTY || drain)) mainQ <= incoming;
      if (accept && (state == TWO || (state == ONE && !drain))) skidQ <= incoming;
    end
  assign bus.in_ready = inReadyQ;
  assign bus.out_valid = state != EMPTY;
  assign bus.out_op = mainQ.ctrl.op;
  assign bus.out_imm = mainQ.ctrl.imm;
  assign bus.out_rs = mainQ.ctrl.rs;
  assign bus.out_pc = PC_W'(mainQ.pc);
  assign bus.out_wr_reg = mainQ.ctrl.wrReg;
  assign bus.out_wr_rc = mainQ.ctrl.wrRc;
  assign bus.out_mem_rd = mainQ.ctrl.memRd;
  assign bus.out_mem_wr = mainQ.ctrl.memWr;
  assign bus.out_branch = mainQ.ctrl.branch;
  assign bus.out_illegal = mainQ.ctrl.illegal;
  assign bus.decode_cnt = cntQ;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: randomized and directed checks of the decode stage against a queue model
module tb_instr_decode_stage;
  import instr_decode_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instr_decode_stage_if #(.PC_W(10), .CNT_W(16)) bus();
  instr_decode_stage #(.PC_W(10), .CNT_W(16)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  int checks = 0;
  int fails = 0;
  logic [18:0] q[$];
  logic readyM = 1'b1;
  logic [15:0] cntM = 16'd0;
  logic lastAcc = 1'b0;

  // {wrReg, wrRc, memRd, memWr, branch, illegal} straight from the opcode table
  function automatic logic [5:0] refFlags(logic [8:0] i);
    int op;
    op = int'(i[8:5]);
    if (op == 13) return i[3] ? 6'b000001 : (i[4] ? 6'b000100 : 6'b101000);
    if (op <= 3) return 6'b010000;
    if (op <= 12) return 6'b100000;
    if (op == 15) return 6'b000010;
    return 6'b000000;
  endfunction

  function automatic logic [29:0] expOut();
    logic [8:0] i;
    logic [9:0] p;
    if (q.size() == 0) return {1'b0, readyM, 28'b0};
    {i, p} = q[0];
    return {1'b1, readyM, i[8:5], i[4:0], i[2:0], p, refFlags(i)};
  endfunction

  function automatic logic [29:0] dutRaw();
    return {bus.out_valid, bus.in_ready, bus.out_op, bus.out_imm, bus.out_rs, bus.out_pc,
            bus.out_wr_reg, bus.out_wr_rc, bus.out_mem_rd, bus.out_mem_wr, bus.out_branch, bus.out_illegal};
  endfunction

  function automatic logic [29:0] dutOut();
    logic [29:0] a;
    a = dutRaw();
    return a[29] ? a : {a[29:28], 28'b0};
  endfunction

  task automatic drive(logic v, logic [8:0] ins, logic [9:0] pc, logic ordy, logic fl);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc = pc;
    bus.out_ready = ordy;
    bus.flush = fl;
  endtask

  // Advance one clock and update the model; outputs are sampled 1 time unit after the edge.
  task automatic step();
    logic acc, drn;
    drn = (q.size() > 0) && bus.out_ready;
    acc = bus.in_valid && readyM && !bus.flush;
    lastAcc = acc;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cntM = 16'd0;
    end else begin
      if (drn) cntM = cntM + 16'd1;
      if (bus.flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back({bus.in_instr, bus.in_pc});
      end
    end
    readyM = q.size() < 2;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 9'd0, 10'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (dutRaw() !== {1'b0, 1'b1, 28'b0}) begin
      fails++;
      $display("FAIL reset_state got=%h exp=%h", dutRaw(), {1'b0, 1'b1, 28'b0});
    end
    checks++;
    if (bus.decode_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_cnt got=%h exp=0000", bus.decode_cnt);
    end
  endtask

  task automatic test_add();
    drive(1'b1, 9'b0111_00011, 10'h155, 1'b1, 1'b0);
    step();
    checks++;
    if (dutOut() !== expOut()) begin
      fails++;
      $display("FAIL add_bundle got=%h exp=%h", dutOut(), expOut());
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_op !== ADD || bus.out_rs !== 3'd3 || bus.out_wr_reg !== 1'b1) begin
      fails++;
      $display("FAIL add_fields got v=%b op=%h rs=%h wr=%b exp v=1 op=7 rs=3 wr=1",
               bus.out_valid, bus.out_op, bus.out_rs, bus.out_wr_reg);
    end
    drive(1'b0, 9'd0, 10'd0, 1'b1, 1'b0);
    step();
    checks++;
    if (bus.decode_cnt !== 16'd1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_cnt got cnt=%h v=%b exp cnt=0001 v=0", bus.decode_cnt, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] items[3];
    int sent;
    sent = 0;
    for (int k = 0; k < 3; k++) items[k] = {9'($urandom), 10'(k * 100 + $urandom_range(0, 99))};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, items[sent][18:10], items[sent][9:0], 1'b0, 1'b0);
      step();
      if (lastAcc) sent++;
    end
    checks++;
    if (bus.in_ready !== 1'b0 || sent != 2) begin
      fails++;
      $display("FAIL b2b_full got ready=%b sent=%0d exp ready=0 sent=2", bus.in_ready, sent);
    end
    checks++;
    if (dutOut() !== expOut() || bus.out_pc !== items[0][9:0]) begin
      fails++;
      $display("FAIL b2b_hold got=%h exp=%h", dutOut(), expOut());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== items[k][9:0]) begin
        fails++;
        $display("FAIL b2b_order%0d got v=%b pc=%h exp v=1 pc=%h", k, bus.out_valid, bus.out_pc, items[k][9:0]);
      end
      if (sent < 3) drive(1'b1, items[sent][18:10], items[sent][9:0], 1'b1, 1'b0);
      else drive(1'b0, 9'd0, 10'd0, 1'b1, 1'b0);
      step();
      if (lastAcc) sent++;
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.decode_cnt !== cntM) begin
      fails++;
      $display("FAIL b2b_drained got v=%b cnt=%h exp v=0 cnt=%h", bus.out_valid, bus.decode_cnt, cntM);
    end
  endtask

  task automatic test_mem();
    drive(1'b1, 9'b1101_10010, 10'h0a1, 1'b1, 1'b0);
    step();
    checks++;
    if (dutOut() !== expOut() || bus.out_mem_wr !== 1'b1 || bus.out_rs !== 3'd2 || bus.out_mem_rd !== 1'b0) begin
      fails++;
      $display("FAIL mem_store got=%h exp=%h", dutOut(), expOut());
    end
    drive(1'b1, 9'b1101_01000, 10'h0a2, 1'b1, 1'b0);
    step();
    checks++;
    if (dutOut() !== expOut() || bus.out_illegal !== 1'b1 ||
        {bus.out_wr_reg, bus.out_wr_rc, bus.out_mem_rd, bus.out_mem_wr, bus.out_branch} !== 5'b0) begin
      fails++;
      $display("FAIL mem_illegal got=%h exp=%h", dutOut(), expOut());
    end
    drive(1'b0, 9'd0, 10'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_branch();
    drive(1'b1, 9'b1111_10101, 10'h3ff, 1'b1, 1'b0);
    step();
    checks++;
    if (dutOut() !== expOut() || bus.out_branch !== 1'b1 || bus.out_imm !== 5'd21 ||
        bus.out_wr_reg !== 1'b0 || bus.out_wr_rc !== 1'b0) begin
      fails++;
      $display("FAIL branch got=%h exp=%h", dutOut(), expOut());
    end
    drive(1'b0, 9'd0, 10'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 9'($urandom), 10'($urandom), 1'b0, 1'b0);
      step();
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_fill got ready=%b v=%b exp ready=0 v=1", bus.in_ready, bus.out_valid);
    end
    c0 = bus.decode_cnt;
    drive(1'b1, 9'($urandom), 10'($urandom), 1'b1, 1'b1);
    step();
    checks++;
    if (bus.decode_cnt !== c0 + 16'd1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_two got cnt=%h v=%b ready=%b exp cnt=%h v=0 ready=1",
               bus.decode_cnt, bus.out_valid, bus.in_ready, c0 + 16'd1);
    end
    drive(1'b0, 9'd0, 10'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 9'($urandom), 10'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      step();
      checks++;
      if (dutOut() !== expOut() || bus.decode_cnt !== cntM) begin
        fails++;
        if (bad++ < 10) $display("FAIL random_c%0d got=%h cnt=%h exp=%h cnt=%h", k, dutOut(), bus.decode_cnt, expOut(), cntM);
      end
    end
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (cntM != 16'hFFFF && guard < 70000) begin
      drive(1'b1, 9'($urandom), 10'($urandom), 1'b1, 1'b0);
      step();
      guard++;
    end
    checks++;
    if (bus.decode_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_preload got=%h exp=ffff", bus.decode_cnt);
    end
    drive(1'b1, 9'($urandom), 10'($urandom), 1'b1, 1'b0);
    step();
    checks++;
    if (bus.decode_cnt !== 16'h0000 || cntM !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_zero got=%h exp=0000", bus.decode_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 9'($urandom), 10'($urandom), 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dutRaw() !== {1'b0, 1'b1, 28'b0} || bus.decode_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid got=%h cnt=%h exp=%h cnt=0000", dutRaw(), bus.decode_cnt, {1'b0, 1'b1, 28'b0});
    end
    drive(1'b0, 9'd0, 10'd0, 1'b1, 1'b0);
    step();
    checks++;
    if (dutOut() !== expOut()) begin
      fails++;
      $display("FAIL reset_mid_after got=%h exp=%h", dutOut(), expOut());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mem();
    test_branch();
    test_flush();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
